// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG scan sequencer: sequencer state encoding,
// TAP reset length and the instruction/ID constants of the attached TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TLR     = 4'd1,
    ST_RTI     = 4'd2,
    ST_SEL_DR  = 4'd3,
    ST_SEL_IR  = 4'd4,
    ST_CAPTURE = 4'd5,
    ST_SHIFT   = 4'd6,
    ST_EXIT1   = 4'd7,
    ST_UPDATE  = 4'd8,
    ST_FINISH  = 4'd9
  } seq_state_e;

  localparam int          TLR_TMS_COUNT = 5;
  localparam int          IR_LEN        = 4;
  localparam logic [3:0]  IR_ABORT      = 4'b1000;
  localparam logic [3:0]  IR_IDCODE     = 4'b1110;
  localparam logic [3:0]  IR_BYPASS     = 4'b1111;
  localparam logic [31:0] IDCODE_VALUE  = 32'h000F_AF01;

endpackage

// File: rtl/jtag_scan_sequencer_if.sv
// Request/response bus between a host and the JTAG scan sequencer.
interface jtag_scan_sequencer_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
);
  logic               reset_tap;
  logic               start;
  logic               is_ir;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] tdi_data;
  logic [MAX_LEN-1:0] tdo_data;
  logic               busy;
  logic               done;
  logic               err;
  logic               tap_synced;

  modport master (
    output reset_tap, start, is_ir, len, tdi_data,
    input  tdo_data, busy, done, err, tap_synced
  );

  modport slave (
    input  reset_tap, start, is_ir, len, tdi_data,
    output tdo_data, busy, done, err, tap_synced
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK generator: divides clk by 2*CLK_DIV while enabled, holds TCK low
// otherwise, and flags the clk edge on which TCK will rise or fall.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap_s;

  assign wrap_s     = (cnt_q == CW'(CLK_DIV - 1));
  assign tck_rise_o = en_i & wrap_s & ~tck_q;
  assign tck_fall_o = en_i & wrap_s &  tck_q;
  assign tck_o      = tck_q;

  // Half-period counter; toggles TCK at each wrap, parks low when disabled.
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = {CW{1'b0}};
      tck_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d = {CW{1'b0}};
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      tck_d = tck_q;
    end
  end

  // Counter and TCK registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end
endmodule

// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG master: runs a TAP reset or one complete IR/DR scan,
// always starting and ending in Run-Test/Idle. The FSM state names the TAP
// state occupied during the current TCK; TMS/TDI for the next TCK are set
// on the clk edge where TCK falls.
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  jtag_scan_sequencer_if.slave  bus,
  output logic                  tck_out,
  output logic                  tms_out,
  output logic                  tdi_out,
  input  logic                  tdo_in
);
  seq_state_e         state_q, state_d;
  logic               tms_q, tms_d, tdi_q, tdi_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               synced_q, synced_d, is_ir_q, is_ir_d, scan_q, scan_d;
  logic [2:0]         tlr_q, tlr_d;
  logic [LEN_W-1:0]   bit_q, bit_d, len_q, len_d;
  logic [MAX_LEN-1:0] din_q, din_d, shreg_q, shreg_d, tdo_q, tdo_d;
  logic               tck_rise_s, tck_fall_s, len_bad_s, last_bit_s;
  logic [MAX_LEN-1:0] din_next_s;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk        (clk),
    .rst        (reset),
    .en_i       (busy_q),
    .tck_o      (tck_out),
    .tck_rise_o (tck_rise_s),
    .tck_fall_o (tck_fall_s)
  );

  assign len_bad_s  = (bus.len == {LEN_W{1'b0}}) || (bus.len > LEN_W'(MAX_LEN));
  assign last_bit_s = (bit_q == len_q - LEN_W'(1));
  assign din_next_s = din_q >> (bit_q + LEN_W'(1));

  assign tms_out        = tms_q;
  assign tdi_out        = tdi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.tap_synced = synced_q;
  assign bus.tdo_data   = tdo_q;

  // Next-state logic: request acceptance, TMS/TDI sequencing, TDO capture.
  always_comb begin
    state_d  = state_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    synced_d = synced_q;
    is_ir_d  = is_ir_q;
    scan_d   = scan_q;
    tlr_d    = tlr_q;
    bit_d    = bit_q;
    len_d    = len_q;
    din_d    = din_q;
    shreg_d  = shreg_q;
    tdo_d    = tdo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.reset_tap) begin
          state_d  = ST_TLR;
          busy_d   = 1'b1;
          tms_d    = 1'b1;
          tdi_d    = 1'b0;
          tlr_d    = 3'd0;
          scan_d   = 1'b0;
          synced_d = 1'b0;
        end else if (bus.start) begin
          if (len_bad_s || !synced_q) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RTI;
            busy_d  = 1'b1;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
            scan_d  = 1'b1;
            is_ir_d = bus.is_ir;
            len_d   = bus.len;
            din_d   = bus.tdi_data;
            shreg_d = {MAX_LEN{1'b0}};
            bit_d   = {LEN_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TLR: begin
        if (tck_fall_s) begin
          if (tlr_q == 3'(TLR_TMS_COUNT - 1)) begin
            state_d = ST_RTI;
            tms_d   = 1'b0;
          end else begin
            tlr_d = tlr_q + 3'd1;
          end
        end else begin
          tlr_d = tlr_q;
        end
      end
      ST_RTI: begin
        if (tck_fall_s) begin
          if (scan_q) begin
            state_d = ST_SEL_DR;
            tms_d   = is_ir_q;
          end else begin
            state_d  = ST_FINISH;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            tms_d    = 1'b0;
            synced_d = 1'b1;
          end
        end else begin
          state_d = ST_RTI;
        end
      end
      ST_SEL_DR: begin
        if (tck_fall_s) begin
          state_d = is_ir_q ? ST_SEL_IR : ST_CAPTURE;
          tms_d   = 1'b0;
        end else begin
          state_d = ST_SEL_DR;
        end
      end
      ST_SEL_IR: begin
        if (tck_fall_s) begin
          state_d = ST_CAPTURE;
          tms_d   = 1'b0;
        end else begin
          state_d = ST_SEL_IR;
        end
      end
      ST_CAPTURE: begin
        if (tck_fall_s) begin
          state_d = ST_SHIFT;
          bit_d   = {LEN_W{1'b0}};
          tdi_d   = din_q[0];
          tms_d   = (len_q == LEN_W'(1));
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_SHIFT: begin
        if (tck_rise_s) begin
          shreg_d = shreg_q | (MAX_LEN'(tdo_in) << bit_q);
        end else if (tck_fall_s) begin
          if (last_bit_s) begin
            state_d = ST_EXIT1;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d = bit_q + LEN_W'(1);
            tdi_d = din_next_s[0];
            tms_d = ((bit_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_EXIT1: begin
        if (tck_fall_s) begin
          state_d = ST_UPDATE;
          tms_d   = 1'b0;
        end else begin
          state_d = ST_EXIT1;
        end
      end
      ST_UPDATE: begin
        if (tck_fall_s) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tms_d   = 1'b0;
          tdo_d   = shreg_q;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any scan and drops sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tms_q    <= 1'b0;
      tdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      synced_q <= 1'b0;
      is_ir_q  <= 1'b0;
      scan_q   <= 1'b0;
      tlr_q    <= 3'd0;
      bit_q    <= {LEN_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      din_q    <= {MAX_LEN{1'b0}};
      shreg_q  <= {MAX_LEN{1'b0}};
      tdo_q    <= {MAX_LEN{1'b0}};
    end else begin
      state_q  <= state_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      synced_q <= synced_d;
      is_ir_q  <= is_ir_d;
      scan_q   <= scan_d;
      tlr_q    <= tlr_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      din_q    <= din_d;
      shreg_q  <= shreg_d;
      tdo_q    <= tdo_d;
    end
  end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer: directed requests push expected
// results; a monitor records TCK/TMS/TDI per transaction and checks on
// every done/err pulse. dut0 (CLK_DIV=2) talks to a behavioural TAP,
// dut1 (CLK_DIV=1) sees TDO tied high.
module tb_jtag_scan_sequencer;
  import jtag_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  typedef struct {
    int          dut;
    bit          is_err;
    int          n_tck;
    logic [63:0] tms;
    logic [63:0] tdi;
    int          busy;
    logic [31:0] tdo;
    bit          synced;
  } exp_t;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_scan_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus0 ();
  jtag_scan_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus1 ();

  logic tck0, tms0, tdi0, tdo0;
  logic tck1, tms1, tdi1;

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(2), .LEN_W(LEN_W)) u_dut0 (
    .clk(clk), .reset(rst), .bus(bus0),
    .tck_out(tck0), .tms_out(tms0), .tdi_out(tdi0), .tdo_in(tdo0)
  );

  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(1), .LEN_W(LEN_W)) u_dut1 (
    .clk(clk), .reset(rst), .bus(bus1),
    .tck_out(tck1), .tms_out(tms1), .tdi_out(tdi1), .tdo_in(1'b1)
  );

  // ---------------- behavioural TAP attached to dut0 ----------------
  tap_e        tap_q;
  logic [3:0]  ir_q, ir_sr;
  logic [31:0] dr_sr;

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR  : T_RTI;
      T_RTI:   return tms ? T_SDR  : T_RTI;
      T_SDR:   return tms ? T_SIR  : T_CDR;
      T_CDR:   return tms ? T_E1DR : T_SHDR;
      T_SHDR:  return tms ? T_E1DR : T_SHDR;
      T_E1DR:  return tms ? T_UDR  : T_PDR;
      T_PDR:   return tms ? T_E2DR : T_PDR;
      T_E2DR:  return tms ? T_UDR  : T_SHDR;
      T_UDR:   return tms ? T_SDR  : T_RTI;
      T_SIR:   return tms ? T_TLR  : T_CIR;
      T_CIR:   return tms ? T_E1IR : T_SHIR;
      T_SHIR:  return tms ? T_E1IR : T_SHIR;
      T_E1IR:  return tms ? T_UIR  : T_PIR;
      T_PIR:   return tms ? T_E2IR : T_PIR;
      T_E2IR:  return tms ? T_UIR  : T_SHIR;
      T_UIR:   return tms ? T_SDR  : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  always @(posedge tck0 or posedge rst) begin
    if (rst) begin
      tap_q <= T_TLR;
      ir_q  <= IR_IDCODE;
      ir_sr <= 4'd0;
      dr_sr <= 32'd0;
    end else begin
      case (tap_q)
        T_TLR:  ir_q  <= IR_IDCODE;
        T_CDR:  dr_sr <= (ir_q == IR_IDCODE) ? IDCODE_VALUE : 32'd0;
        T_SHDR: dr_sr <= {tdi0, dr_sr[31:1]};
        T_CIR:  ir_sr <= 4'b0001;
        T_SHIR: ir_sr <= {tdi0, ir_sr[3:1]};
        T_UIR:  ir_q  <= ir_sr;
        default: ;
      endcase
      tap_q <= tap_next(tap_q, tms0);
    end
  end

  always @(negedge tck0 or posedge rst) begin
    if (rst) tdo0 <= 1'b0;
    else if (tap_q == T_SHDR) tdo0 <= dr_sr[0];
    else if (tap_q == T_SHIR) tdo0 <= ir_sr[0];
    else tdo0 <= 1'b0;
  end

  // ---------------- scoreboard and monitor ----------------
  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_tck    [2];
  int          busy_cyc [2];
  logic [63:0] acc_tms  [2];
  logic [63:0] acc_tdi  [2];
  logic        prev_tck [2];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input bit is_err, input int n, input logic [63:0] tms,
                          input logic [63:0] tdi, input int busy, input logic [31:0] tdo, input bit synced);
    exp_t e;
    e.dut = d; e.is_err = is_err; e.n_tck = n; e.tms = tms; e.tdi = tdi;
    e.busy = busy; e.tdo = tdo; e.synced = synced;
    sb_q.push_back(e);
  endtask

  task automatic mon_clear(input int d);
    n_tck[d] = 0; busy_cyc[d] = 0; acc_tms[d] = 64'd0; acc_tdi[d] = 64'd0; prev_tck[d] = 1'b0;
  endtask

  task automatic mon_step(input int d, input logic tck, input logic tms, input logic tdi,
                          input logic busy, input logic done, input logic err,
                          input logic synced, input logic [31:0] tdo);
    exp_t e;
    if (busy) busy_cyc[d]++;
    if (tck && !prev_tck[d]) begin
      if (n_tck[d] < 64) begin
        acc_tms[d][n_tck[d]] = tms;
        acc_tdi[d][n_tck[d]] = tdi;
      end
      n_tck[d]++;
    end
    prev_tck[d] = tck;
    if (done || err) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_event: dut%0d done=%0b err=%0b with nothing expected", d, done, err);
      end else begin
        e = sb_q.pop_front();
        cmp("dut_index",   64'(d), 64'(e.dut));
        cmp("err_done",    {62'd0, err, done}, e.is_err ? 64'd2 : 64'd1);
        cmp("tck_count",   64'(n_tck[d]), 64'(e.n_tck));
        cmp("tms_seq",     acc_tms[d], e.tms);
        cmp("tdi_seq",     acc_tdi[d], e.tdi);
        cmp("busy_cycles", 64'(busy_cyc[d]), 64'(e.busy));
        cmp("busy_low",    64'(busy), 64'd0);
        cmp("tdo_data",    64'(tdo), 64'(e.tdo));
        cmp("tap_synced",  64'(synced), 64'(e.synced));
      end
      mon_clear(d);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_clear(0);
      mon_clear(1);
    end else begin
      mon_step(0, tck0, tms0, tdi0, bus0.busy, bus0.done, bus0.err, bus0.tap_synced, bus0.tdo_data);
      mon_step(1, tck1, tms1, tdi1, bus1.busy, bus1.done, bus1.err, bus1.tap_synced, bus1.tdo_data);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input int d, input logic rt, input logic st, input logic ir,
                       input logic [LEN_W-1:0] ln, input logic [31:0] data);
    @(negedge clk);
    if (d == 0) begin
      bus0.reset_tap = rt; bus0.start = st; bus0.is_ir = ir; bus0.len = ln; bus0.tdi_data = data;
    end else begin
      bus1.reset_tap = rt; bus1.start = st; bus1.is_ir = ir; bus1.len = ln; bus1.tdi_data = data;
    end
    @(negedge clk);
    bus0.reset_tap = 1'b0; bus0.start = 1'b0;
    bus1.reset_tap = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus0.busy && !bus1.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: %0d expected events still pending", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_tck"},    64'(tck0), 64'd0);
    cmp({tag, "_tms"},    64'(tms0), 64'd0);
    cmp({tag, "_tdi"},    64'(tdi0), 64'd0);
    cmp({tag, "_busy"},   64'(bus0.busy), 64'd0);
    cmp({tag, "_done"},   64'(bus0.done), 64'd0);
    cmp({tag, "_err"},    64'(bus0.err), 64'd0);
    cmp({tag, "_synced"}, 64'(bus0.tap_synced), 64'd0);
    cmp({tag, "_tdo"},    64'(bus0.tdo_data), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    int rises;
    bus0.reset_tap = 1'b0; bus0.start = 1'b0; bus0.is_ir = 1'b0; bus0.len = 6'd0; bus0.tdi_data = 32'd0;
    bus1.reset_tap = 1'b0; bus1.start = 1'b0; bus1.is_ir = 1'b0; bus1.len = 6'd0; bus1.tdi_data = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scan before any TAP reset is rejected.
    push_exp(0, 1'b1, 0, 64'd0, 64'd0, 0, 32'd0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b0, 6'd4, 32'hF);
    wait_idle(50);

    // TAP reset: TMS 1,1,1,1,1,0, busy 12*CLK_DIV.
    push_exp(0, 1'b0, 6, 64'h1F, 64'd0, 24, 32'd0, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    wait_idle(200);

    // Length rejections.
    push_exp(0, 1'b1, 0, 64'd0, 64'd0, 0, 32'd0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h1);
    wait_idle(50);
    push_exp(0, 1'b1, 0, 64'd0, 64'd0, 0, 32'd0, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 6'd33, 32'h1);
    wait_idle(50);

    // IR scan loading IdCode; TAP captures 4'b0001.
    push_exp(0, 1'b0, 10, 64'h183, 64'hE0, 40, 32'h1, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b1, 6'd4, {28'd0, IR_IDCODE});
    wait_idle(300);

    // 32-bit DR scan reads IDCODE; a start mid-scan must be ignored.
    push_exp(0, 1'b0, 37, 64'h0000_000C_0000_0001, 64'h0000_0005_2D28_7878, 148, IDCODE_VALUE, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b0, 6'd32, 32'hA5A5_0F0F);
    repeat (30) @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b1, 6'd0, 32'hFFFF_FFFF);
    wait_idle(400);

    // reset_tap and start together: reset wins, tdo_data holds.
    push_exp(0, 1'b0, 6, 64'h1F, 64'd0, 24, IDCODE_VALUE, 1'b1);
    drive(0, 1'b1, 1'b1, 1'b0, 6'd4, 32'h3);
    wait_idle(200);

    // Reset asserted during shift bit 10 (14th TCK) of a DR scan.
    drive(0, 1'b0, 1'b1, 1'b0, 6'd32, 32'h1234_5678);
    seen  = 1'b0;
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tck0 && !prev_tck[0]) rises++;
      if (rises >= 14) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL midscan_wait: only %0d TCK rises seen", rises);
    end
    #2 rst = 1'b1;
    #1 check_reset_vals("midscan");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(0, 1'b1, 0, 64'd0, 64'd0, 0, 32'd0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b0, 6'd4, 32'h5);
    wait_idle(50);

    // CLK_DIV=1 instance: TAP reset then 1-bit DR scan with TDO tied high.
    push_exp(1, 1'b0, 6, 64'h1F, 64'd0, 12, 32'd0, 1'b1);
    drive(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    wait_idle(100);
    push_exp(1, 1'b0, 6, 64'h19, 64'h8, 12, 32'h1, 1'b1);
    drive(1, 1'b0, 1'b1, 1'b0, 6'd1, 32'h1);
    wait_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
